// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 exception/interrupt controller for the P7 pipeline.
// Holds SR (12), Cause (13), EPC (14) and PRId (15). It raises a one-cycle
// redirect request when an exception or an enabled interrupt arrives and
// records the victim state. It serves mtc0/mfc0 and supplies the eret
// return address.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous reset, active low
//   en           mtc0 write enable (M stage)
//   cp0_addr     CP0 register number for read and write
//   cp0_wdata    mtc0 write data
//   cp0_rdata    mfc0 read data (combinational, pre-write value)
//   vpc          PC of the instruction in M stage
//   bd_in        victim sits in a branch delay slot
//   exc_code_in  pipeline exception code, 0 = none
//   hw_int       level-sensitive hardware interrupt lines
//   eret         eret instruction in M stage
//   req          redirect/flush request (combinational)
//   epc_out      current EPC, the eret return target (combinational)
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h0000_2024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;

  // Both request sources are masked by EXL, so a handler is never re-entered
  // and req lasts a single cycle per event.
  always_comb begin
    int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code_in != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // Pending interrupts are visible regardless of masks.
    ip_d       = hw_int;

    if (req) begin
      // Taking the event wins over any same-cycle mtc0 or eret.
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      bd_d       = bd_in;
      epc_d      = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      if (en) begin
        case (cp0_addr)
          ADDR_SR: begin
            im_d  = cp0_wdata[15:10];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
          end
          ADDR_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
      // Placed after the SR write so eret's EXL clear takes precedence.
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Reads return current register contents; a same-cycle write is not
  // forwarded.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
      ADDR_CAUSE: cp0_rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//
// Directed bench for cp0_exc_ctrl. Each step drives inputs just after a
// rising edge, queues the expected combinational outputs, and compares them
// at the following falling edge.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h0000_2024;

  localparam int SEL_REQ = 0;
  localparam int SEL_EPC = 1;
  localparam int SEL_RD  = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_ctrl #(.PRID(PRID)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .eret        (eret),
    .req         (req),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sel)
        SEL_REQ: obs = {31'd0, req};
        SEL_EPC: obs = epc_out;
        default: obs = cp0_rdata;
      endcase
      chk(it.tag, obs, it.exp);
    end
  endtask

  // Compare at the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    en          = 1'b0;
    cp0_addr    = 5'd0;
    cp0_wdata   = 32'd0;
    vpc         = 32'd0;
    bd_in       = 1'b0;
    exc_code_in = 5'd0;
    hw_int      = 6'd0;
    eret        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    cp0_addr = 5'd12;
    push("rst_req", SEL_REQ, 32'd0);
    push("rst_epc_out", SEL_EPC, 32'd0);
    push("rst_sr", SEL_RD, 32'd0);
    step();
    cp0_addr = 5'd13; push("rst_cause", SEL_RD, 32'd0); step();
    cp0_addr = 5'd14; push("rst_epc", SEL_RD, 32'd0); step();
    cp0_addr = 5'd15; push("prid", SEL_RD, PRID); step();
    cp0_addr = 5'd20; push("unmapped", SEL_RD, 32'd0); step();

    // Reset mid-handler
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0002; step();
    cp0_addr = 5'd14; cp0_wdata = 32'h0000_3010; step();
    en = 1'b0; cp0_addr = 5'd12; exc_code_in = 5'd4;
    push("t1_sr_exl", SEL_RD, 32'h0000_0002);
    push("t1_exl_masks_exc", SEL_REQ, 32'd0);
    push("t1_epc_out", SEL_EPC, 32'h0000_3010);
    step();
    exc_code_in = 5'd0;
    reset = 1'b0;
    #2;
    push("t1_async_req", SEL_REQ, 32'd0);
    push("t1_async_epc", SEL_EPC, 32'd0);
    push("t1_async_sr", SEL_RD, 32'd0);
    drain();
    reset = 1'b1;
    cp0_addr = 5'd13; push("t1_cause", SEL_RD, 32'd0); step();
    cp0_addr = 5'd14; push("t1_epc", SEL_RD, 32'd0); step();

    // AdEL
    vpc = 32'h0000_2ffc; bd_in = 1'b0; exc_code_in = 5'd4;
    push("t2_req", SEL_REQ, 32'd1);
    step();
    cp0_addr = 5'd13;
    push("t2_req_once", SEL_REQ, 32'd0);
    push("t2_cause", SEL_RD, 32'h0000_0010);
    push("t2_epc_out", SEL_EPC, 32'h0000_2ffc);
    step();
    cp0_addr = 5'd12; push("t2_sr_exl", SEL_RD, 32'h0000_0002); step();
    exc_code_in = 5'd0; eret = 1'b1;
    push("t2_eret_epc", SEL_EPC, 32'h0000_2ffc);
    step();
    eret = 1'b0; push("t2_sr_cleared", SEL_RD, 32'd0); step();

    // Interrupt beats exception
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    push("t3_mfc0_old", SEL_RD, 32'd0);
    step();
    en = 1'b0; hw_int = 6'b000001; exc_code_in = 5'd10; vpc = 32'h0000_3000;
    push("t3_req", SEL_REQ, 32'd1);
    step();
    exc_code_in = 5'd0; cp0_addr = 5'd13;
    push("t3_cause", SEL_RD, 32'h0000_0400);
    push("t3_epc_out", SEL_EPC, 32'h0000_3000);
    push("t3_req_off", SEL_REQ, 32'd0);
    step();
    cp0_addr = 5'd12; push("t3_sr", SEL_RD, 32'h0000_0403); step();
    hw_int = 6'd0; eret = 1'b1;
    push("t3_eret_epc", SEL_EPC, 32'h0000_3000);
    step();
    eret = 1'b0;

    // Delay slot
    exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3008;
    push("t4_req", SEL_REQ, 32'd1);
    step();
    exc_code_in = 5'd0; bd_in = 1'b0; cp0_addr = 5'd13;
    push("t4_cause", SEL_RD, 32'h8000_0030);
    push("t4_epc", SEL_EPC, 32'h0000_3004);
    step();

    // eret with an enabled interrupt still pending
    hw_int = 6'b000001; eret = 1'b1; vpc = 32'h0000_3200;
    push("t5_eret_epc", SEL_EPC, 32'h0000_3004);
    push("t5_req_masked", SEL_REQ, 32'd0);
    step();
    eret = 1'b0;
    push("t5_int_after_eret", SEL_REQ, 32'd1);
    step();
    hw_int = 6'd0; cp0_addr = 5'd13;
    push("t5_cause", SEL_RD, 32'h0000_0400);
    push("t5_epc", SEL_EPC, 32'h0000_3200);
    step();
    en = 1'b1; eret = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
    push("t5_sr_before", SEL_RD, 32'h0000_0403);
    step();
    en = 1'b0; eret = 1'b0;
    push("t5_eret_over_mtc0", SEL_RD, 32'h0000_0401);
    step();

    // mtc0 EPC colliding with an exception
    en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_5000;
    exc_code_in = 5'd5; vpc = 32'h0000_3100;
    push("t6_req", SEL_REQ, 32'd1);
    push("t6_mfc0_old", SEL_RD, 32'h0000_3200);
    step();
    en = 1'b0; exc_code_in = 5'd0;
    push("t6_write_dropped", SEL_RD, 32'h0000_3100);
    push("t6_epc_out", SEL_EPC, 32'h0000_3100);
    step();
    cp0_addr = 5'd13; push("t6_cause", SEL_RD, 32'h0000_0014); step();

    // Cause is not writable
    en = 1'b1; cp0_wdata = 32'hffff_ffff; step();
    en = 1'b0; push("cause_ro", SEL_RD, 32'h0000_0014); step();

    // mtc0 EPC feeds eret target
    en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234; step();
    en = 1'b0; eret = 1'b1;
    push("mtc0_epc_eret", SEL_EPC, 32'h0000_1234);
    step();
    eret = 1'b0;

    // Delay-slot EPC wraps modulo 2^32
    exc_code_in = 5'd4; bd_in = 1'b1; vpc = 32'd0;
    push("wrap_req", SEL_REQ, 32'd1);
    step();
    exc_code_in = 5'd0; bd_in = 1'b0; cp0_addr = 5'd13;
    push("wrap_epc", SEL_EPC, 32'hffff_fffc);
    push("wrap_cause", SEL_RD, 32'h8000_0010);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the P7 pipeline. It receives exception codes and the victim PC from the pipeline. It raises the redirect request that makes the fetch PC jump to the handler at 0x4180. It holds SR, Cause, EPC and PRId, serves mtc0/mfc0 accesses, and supplies the return address on eret.

Parameters:
PRID, 32'h0000_2024, constant value returned on reads of register 15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
en  input  1  mtc0 write enable (M stage).
cp0_addr  input  5  CP0 register number for read and write.
cp0_wdata  input  32  mtc0 write data.
cp0_rdata  output  32  mfc0 read data, combinational.
vpc  input  32  PC of the instruction in M stage (victim PC).
bd_in  input  1  victim instruction is in a branch delay slot.
exc_code_in  input  5  pipeline exception code; 0 = none (4 = AdEL, 5 = AdES, 10 = RI, 12 = Ov).
hw_int  input  6  hardware interrupt lines, level sensitive.
eret  input  1  eret instruction in M stage.
req  output  1  exception/interrupt redirect request to PC and to pipeline flush logic.
epc_out  output  32  current EPC, combinational; eret return target.

Behaviour:
- Register fields:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC (14): full 32 bits.
  - PRId (15): returns PRID.
- Reset (reset = 0, asynchronous): SR, Cause and EPC clear to 0. Consequently req = 0, epc_out = 0 and cp0_rdata reads 0 for registers 12–14. Reset asserted mid-handler also clears EXL.
- Request generation (combinational, same cycle):
  - int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
  - exc_req = (exc_code_in != 0) & ~SR.EXL.
  - req = int_req | exc_req.
- On a rising edge with req = 1:
  - EXL <= 1.
  - ExcCode <= 0 if int_req, else exc_code_in. Interrupt has priority over exception.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc - 32'd4 : vpc. Subtraction is modulo 2^32.
  - Pending en and eret in that cycle are discarded.
- Once EXL = 1, req stays 0 for the rest of the handler. req therefore lasts exactly one cycle per event unless the pipeline keeps presenting a new event.
- Cause.IP <= hw_int on every non-reset edge, independent of masks.
- mtc0 (en = 1, req = 0), applied at the edge:
  - addr 12 writes IM, EXL and IE from the corresponding wdata bits.
  - addr 14 writes EPC.
  - addr 13, 15 and all other addresses are ignored.
- eret (eret = 1, req = 0): EXL <= 0 at the edge; epc_out already presents EPC in that same cycle.
  - en and eret in the same cycle: both apply; eret's EXL clear overrides an SR write's EXL bit.
- mfc0: cp0_rdata returns the register's value before any same-cycle write (no write-through bypass). Unmapped addresses return 0.
- No other state exists. The handler address is fixed at 0x4180 by the PC, not by this block.

Test Plan:
1. Reset mid-handler: EXL = 1, EPC = 0x3010, then pull reset low for half a cycle with no clock edge -> SR = Cause = EPC = 0 immediately, req = 0.
2. AdEL: exc_code_in = 4, vpc = 0x2ffc, bd_in = 0, SR = 0 -> req = 1 in the same cycle. Next edge: ExcCode = 4, EPC = 0x2ffc, EXL = 1. req = 0 on the following cycle even with exc_code_in still 4.
3. Interrupt: mtc0 SR = 0x0000_0401, then hw_int = 6'b000001 with exc_code_in = 10 -> req = 1. After the edge: ExcCode = 0, IP[10] = 1, EPC = vpc.
4. Delay slot: exc_code_in = 12, bd_in = 1, vpc = 0x3008 -> EPC = 0x3004, Cause = 0x8000_0030.
5. eret: EXL = 1, EPC = 0x3004, eret = 1 -> epc_out = 0x3004 in that cycle, EXL = 0 after the edge. If hw_int is still enabled, req rises the next cycle.
6. Collision: en = 1, addr 14, wdata = 0x5000 in the same cycle as exc_code_in = 5, vpc = 0x3100 -> EPC = 0x3100 (write dropped); mfc0 of EPC in that cycle returns the old value.
